// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and width helper for the debouncer family
package debounce_pkg;

    localparam int DEB_TICK_DIV_DEFAULT   = 250000;
    localparam int DEB_STABLE_CNT_DEFAULT = 4;

    // Counter width for values 0..value-1, never narrower than one bit
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debounce_tick.sv
// rtl/debounce_tick.sv - clock-enable tick generator, one strobe every TICK_DIV enabled cycles
module debounce_tick
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEB_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW   = clog2_min1(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          at_last;

    // Next divider value: advance and wrap only while enabled, otherwise hold
    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // at_last is a registered copy of (cnt == LAST) so the strobe needs no compare after the flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            at_last <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            at_last <= (cnt_next == LAST);
        end
    end

    // Gating by en keeps the strobe low on every disabled cycle, even while parked at LAST
    assign tick = at_last & en;

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel debouncer with synchronisers, stability counters and edge pulses
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   TICK_DIV    = DEB_TICK_DIV_DEFAULT,
    parameter int   STABLE_CNT  = DEB_STABLE_CNT_DEFAULT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_rise,
    output logic [N_CH-1:0] pb_fall,
    output logic            sample_tick
);

    localparam int            SW    = clog2_min1(STABLE_CNT + 1);
    localparam logic [SW-1:0] SLAST = SW'(STABLE_CNT - 1);

    logic [N_CH-1:0] sync_a;
    logic [N_CH-1:0] sync_b;

    // Two-stage synchroniser, runs every cycle regardless of en; reset to idle level so release is quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= {N_CH{RESET_LEVEL}};
            sync_b <= {N_CH{RESET_LEVEL}};
        end else begin
            sync_a <= pb_in;
            sync_b <= sync_a;
        end
    end

    debounce_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (sample_tick)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SW-1:0] stab_cnt;
        logic          lvl_q;
        logic          rise_q;
        logic          fall_q;

        // On each tick: a matching sample restarts acceptance, STABLE_CNT differing samples in a row flip the level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stab_cnt <= '0;
                lvl_q    <= RESET_LEVEL;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sample_tick) begin
                    if (sync_b[g] == lvl_q) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == SLAST) begin
                        lvl_q    <= sync_b[g];
                        stab_cnt <= '0;
                        rise_q   <= sync_b[g];
                        fall_q   <= ~sync_b[g];
                    end else begin
                        stab_cnt <= stab_cnt + SW'(1);
                    end
                end
            end
        end

        assign pb_level[g] = lvl_q;
        assign pb_rise[g]  = rise_q;
        assign pb_fall[g]  = fall_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - randomized and directed bench for debounce_multi against a sample-stream model
module tb_debounce_multi;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] pb_in;
    logic [N-1:0] pb_level, pb_rise, pb_fall;
    logic         sample_tick;
    logic [N-1:0] lvl1, rise1, fall1;
    logic         tick1;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: input history, enabled-edge count, consecutive-differing-sample run per channel
    logic [N-1:0] m_h1, m_h2, m_lvl, m_rise, m_fall;
    int           m_run [N];
    int           m_ecnt;

    debounce_multi #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .pb_in(pb_in),
        .pb_level(pb_level), .pb_rise(pb_rise), .pb_fall(pb_fall), .sample_tick(sample_tick)
    );

    debounce_multi #(.N_CH(N), .TICK_DIV(TD), .STABLE_CNT(SC), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .pb_in(pb_in),
        .pb_level(lvl1), .pb_rise(rise1), .pb_fall(fall1), .sample_tick(tick1)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_ecnt = 0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
    endtask

    // One clock edge with inputs p/e held during the preceding cycle
    task automatic model_edge(input logic [N-1:0] p, input logic e);
        bit tk;
        tk = e && ((m_ecnt % TD) == TD - 1);
        m_rise = '0; m_fall = '0;
        if (tk) begin
            for (int c = 0; c < N; c++) begin
                if (m_h2[c] == m_lvl[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] == SC) begin
                        m_lvl[c] = m_h2[c];
                        m_run[c] = 0;
                        if (m_h2[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                    end
                end
            end
        end
        if (e) m_ecnt++;
        m_h2 = m_h1;
        m_h1 = p;
    endtask

    function automatic logic [12:0] exp_vec();
        return {m_lvl, m_rise, m_fall, en && ((m_ecnt % TD) == TD - 1)};
    endfunction

    task automatic cyc(input logic [N-1:0] p, input logic e);
        pb_in = p;
        en    = e;
        @(posedge clk);
        if (rst) model_reset(); else model_edge(p, e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat;
        int rc [N];
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'hF, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== 13'd0) begin
                n_fail++; $display("FAIL reset_hold cycle %0d: got %h want 0", i, {pb_level, pb_rise, pb_fall, sample_tick});
            end
        end
        rst = 1'b0;
        lat = -1;
        for (int c = 0; c < N; c++) rc[c] = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(4'hF, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL reset_release_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            for (int c = 0; c < N; c++) if (pb_rise[c]) rc[c]++;
            if (lat < 0 && pb_level == 4'hF) lat = i;
        end
        n_assert++;
        if (lat < 11 || lat > 14) begin
            n_fail++; $display("FAIL reset_release_latency: got %0d want 11..14", lat);
        end
        for (int c = 0; c < N; c++) begin
            n_assert++;
            if (rc[c] != 1) begin
                n_fail++; $display("FAIL reset_release_rise_count ch%0d: got %0d want 1", c, rc[c]);
            end
        end
    endtask

    task automatic test_single_rise();
        int lat, rc, fc;
        for (int i = 0; i < 20; i++) begin
            cyc(4'h0, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL single_rise_prep_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
        end
        lat = -1; rc = 0; fc = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(4'h1, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL single_rise_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            if (pb_rise[0]) rc++;
            if (pb_fall != 4'h0) fc++;
            if (lat < 0 && pb_level[0]) lat = i;
        end
        n_assert++;
        if (lat < 11 || lat > 14) begin
            n_fail++; $display("FAIL single_rise_latency: got %0d want 11..14", lat);
        end
        n_assert++;
        if (rc != 1 || fc != 0) begin
            n_fail++; $display("FAIL single_rise_pulses: got rise=%0d fall=%0d want rise=1 fall=0", rc, fc);
        end
        n_assert++;
        if (pb_level[3:1] !== 3'b000) begin
            n_fail++; $display("FAIL single_rise_others: got %b want 000", pb_level[3:1]);
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] p;
        int pulses, highs;
        pulses = 0; highs = 0;
        for (int i = 0; i < 60; i++) begin
            p = 4'h1;
            if (i < 40) p[1] = ((i / 5) % 2) == 0;
            cyc(p, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            if (pb_rise[1] || pb_fall[1]) pulses++;
            if (pb_level[1]) highs++;
        end
        n_assert++;
        if (pulses != 0 || highs != 0) begin
            n_fail++; $display("FAIL bounce_filtered: got pulses=%0d high_cycles=%0d want 0 0", pulses, highs);
        end
    endtask

    task automatic test_simultaneous();
        int r2, r3, f2, f3;
        r2 = -1; r3 = -1; f2 = -1; f3 = -1;
        for (int i = 0; i < 40; i++) begin
            cyc((i < 20) ? 4'hD : 4'h1, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL simultaneous_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            if (pb_rise[2]) r2 = i;
            if (pb_rise[3]) r3 = i;
            if (pb_fall[2]) f2 = i;
            if (pb_fall[3]) f3 = i;
        end
        n_assert++;
        if (r2 < 0 || r2 != r3) begin
            n_fail++; $display("FAIL simultaneous_rise: got ch2@%0d ch3@%0d want same cycle", r2, r3);
        end
        n_assert++;
        if (f2 < 0 || f2 != f3) begin
            n_fail++; $display("FAIL simultaneous_fall: got ch2@%0d ch3@%0d want same cycle", f2, f3);
        end
    endtask

    task automatic test_enable_hold();
        int bad_tick, bad_lvl, lat;
        for (int i = 0; i < 20; i++) cyc(4'h0, 1'b1);
        n_assert++;
        if (pb_level !== 4'h0) begin
            n_fail++; $display("FAIL enable_prep_level: got %h want 0", pb_level);
        end
        bad_tick = 0; bad_lvl = 0; lat = -1;
        for (int i = 0; i < 6; i++) cyc(4'h1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            cyc(4'h1, 1'b0);
            if (sample_tick !== 1'b0) bad_tick++;
            if (pb_level[0] !== 1'b0) bad_lvl++;
        end
        n_assert++;
        if (bad_tick != 0 || bad_lvl != 0) begin
            n_fail++; $display("FAIL enable_hold: got tick_cycles=%0d level_changes=%0d want 0 0", bad_tick, bad_lvl);
        end
        for (int i = 1; i <= 20; i++) begin
            cyc(4'h1, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL enable_resume_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            if (lat < 0 && pb_level[0]) lat = i;
        end
        n_assert++;
        if (lat < 0) begin
            n_fail++; $display("FAIL enable_resume_accept: got no acceptance within 20 cycles want level[0]=1");
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        for (int i = 0; i < 7; i++) cyc(4'h0, 1'b1);
        n_assert++;
        if (pb_level[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_prep: got %b want 1", pb_level[0]);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_assert++;
        if (pb_level[0] !== 1'b0 || pb_fall !== 4'h0) begin
            n_fail++; $display("FAIL reset_mid_async: got level0=%b fall=%h want 0 0", pb_level[0], pb_fall);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(4'h0, 1'b1);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'h0, 1'b1);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            if (pb_rise != 4'h0 || pb_fall != 4'h0) pulses++;
        end
        n_assert++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL reset_mid_no_pulse: got %0d pulse cycles want 0", pulses);
        end
    endtask

    task automatic test_reset_level1();
        int pulses, bad;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'hF, 1'b1);
            n_assert++;
            if ({lvl1, rise1, fall1, tick1} !== {4'hF, 9'd0}) begin
                n_fail++; $display("FAIL level1_reset_hold cycle %0d: got %h want %h", i, {lvl1, rise1, fall1, tick1}, {4'hF, 9'd0});
            end
        end
        rst = 1'b0;
        pulses = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'hF, 1'b1);
            if (rise1 != 4'h0 || fall1 != 4'h0) pulses++;
            if (lvl1 !== 4'hF) bad++;
        end
        n_assert++;
        if (pulses != 0 || bad != 0) begin
            n_fail++; $display("FAIL level1_release: got pulses=%0d level_bad=%0d want 0 0", pulses, bad);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] p;
        logic         e;
        p = pb_in;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) if ($urandom_range(0, 15) == 0) p[c] = ~p[c];
            e = ($urandom_range(0, 7) != 0);
            cyc(p, e);
            n_assert++;
            if ({pb_level, pb_rise, pb_fall, sample_tick} !== exp_vec()) begin
                n_fail++; $display("FAIL random_model cycle %0d: got %h want %h", i, {pb_level, pb_rise, pb_fall, sample_tick}, exp_vec());
            end
            n_assert++;
            if ((pb_rise & pb_fall) !== 4'h0) begin
                n_fail++; $display("FAIL random_exclusive cycle %0d: got rise=%h fall=%h want disjoint", i, pb_rise, pb_fall);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        pb_in = 4'hF;
        model_reset();
        test_reset();
        test_single_rise();
        test_bounce();
        test_simultaneous();
        test_enable_hold();
        test_reset_mid();
        test_reset_level1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
